// File: rtl/vga_sync_gen.sv
`timescale 1ns/1ps
// Pixel-rate divider and raster walker: produces aligned hCount/vCount plus
// sync, blanking and frame-start flags, all registered on the same clk edge.
module vga_sync_gen #(
  parameter int CLK_DIV = 4,
  parameter int H_TOTAL = 800,
  parameter int H_SYNC  = 96,
  parameter int H_START = 144,
  parameter int H_END   = 783,
  parameter int V_TOTAL = 525,
  parameter int V_SYNC  = 2,
  parameter int V_START = 35,
  parameter int V_END   = 514
) (
  input  logic       clk,
  input  logic       rst,
  output logic       pix_en,
  output logic [9:0] hCount,
  output logic [9:0] vCount,
  output logic       hSync,
  output logic       vSync,
  output logic       bright,
  output logic       frame_start
);

  localparam int DIV_W = ($clog2(CLK_DIV) < 2) ? 2 : $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_SYNC_C  = 10'(H_SYNC);
  localparam logic [9:0] V_SYNC_C  = 10'(V_SYNC);
  localparam logic [9:0] H_START_C = 10'(H_START);
  localparam logic [9:0] H_END_C   = 10'(H_END);
  localparam logic [9:0] V_START_C = 10'(V_START);
  localparam logic [9:0] V_END_C   = 10'(V_END);

  logic [DIV_W-1:0] div;
  logic [9:0]       h_next;
  logic [9:0]       v_next;
  logic             frame_wrap;

  function automatic logic hsync_level(input logic [9:0] h);
    return (h >= H_SYNC_C);
  endfunction

  function automatic logic vsync_level(input logic [9:0] v);
    return (v >= V_SYNC_C);
  endfunction

  function automatic logic in_window(input logic [9:0] h, input logic [9:0] v);
    return (h >= H_START_C) && (h <= H_END_C) && (v >= V_START_C) && (v <= V_END_C);
  endfunction

  // Divider stage: pix_en is a plain decode so it is 0 while div is held at 0 in reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div <= '0;
    end else if (pix_en) begin
      div <= '0;
    end else begin
      div <= div + DIV_W'(1);
    end
  end

  assign pix_en = (div == DIV_LAST);

  always_comb begin
    h_next     = hCount;
    v_next     = vCount;
    frame_wrap = 1'b0;
    if (pix_en) begin
      if (hCount == H_LAST) begin
        h_next = '0;
        if (vCount == V_LAST) begin
          v_next     = '0;
          frame_wrap = 1'b1;
        end else begin
          v_next = vCount + 10'd1;
        end
      end else begin
        h_next = hCount + 10'd1;
      end
    end
  end

  // Raster stage: flags are derived from the next-state counters so they land
  // on the same edge as the counts they describe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hCount      <= '0;
      vCount      <= '0;
      hSync       <= 1'b0;
      vSync       <= 1'b0;
      bright      <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      hCount      <= h_next;
      vCount      <= v_next;
      hSync       <= hsync_level(h_next);
      vSync       <= vsync_level(v_next);
      bright      <= in_window(h_next, v_next);
      frame_start <= frame_wrap;
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
`timescale 1ns/1ps
// Bench for vga_sync_gen: a shrunken raster instance for frame-level behaviour and
// a full 800x525 instance for first-line and line-wrap behaviour.
module tb_vga_sync_gen;

  localparam int D = 4, HT = 24, HS = 4, HST = 6, HEN = 19, VT = 10, VS = 2, VST = 3, VEN = 7;
  localparam int FD = 4, FHT = 800, FHS = 96, FHST = 144, FHEN = 783;
  localparam int FVT = 525, FVS = 2, FVST = 35, FVEN = 514;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       s_pe, s_hs, s_vs, s_br, s_fs;
  logic [9:0] s_h, s_v;
  logic       f_pe, f_hs, f_vs, f_br, f_fs;
  logic [9:0] f_h, f_v;

  vga_sync_gen #(.CLK_DIV(D), .H_TOTAL(HT), .H_SYNC(HS), .H_START(HST), .H_END(HEN),
                 .V_TOTAL(VT), .V_SYNC(VS), .V_START(VST), .V_END(VEN)) dut_small (
    .clk(clk), .rst(rst), .pix_en(s_pe), .hCount(s_h), .vCount(s_v),
    .hSync(s_hs), .vSync(s_vs), .bright(s_br), .frame_start(s_fs));

  vga_sync_gen dut_full (
    .clk(clk), .rst(rst), .pix_en(f_pe), .hCount(f_h), .vCount(f_v),
    .hSync(f_hs), .vSync(f_vs), .bright(f_br), .frame_start(f_fs));

  // Clock edges seen since reset release; the reference model is a pure function of it.
  int n;
  always @(posedge clk or negedge rst) begin
    if (!rst) n <= 0;
    else      n <= n + 1;
  end

  int checks = 0;
  int failures = 0;
  bit mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pk(input logic pe, input logic hs, input logic vs,
                                     input logic br, input logic fs,
                                     input logic [9:0] h, input logic [9:0] v);
    return {7'd0, pe, hs, vs, br, fs, h, v};
  endfunction

  function automatic logic [31:0] model(input int k, input int d, input int ht, input int hs,
                                        input int hst, input int hen, input int vt, input int vs,
                                        input int vst, input int ven);
    int p, h, v;
    logic pe, hsl, vsl, br, fs;
    p   = k / d;
    h   = p % ht;
    v   = (p / ht) % vt;
    pe  = (k % d) == d - 1;
    hsl = h >= hs;
    vsl = v >= vs;
    br  = (h >= hst) && (h <= hen) && (v >= vst) && (v <= ven);
    fs  = (k > 0) && (k % (d * ht * vt) == 0);
    return pk(pe, hsl, vsl, br, fs, 10'(h), 10'(v));
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      check("mon_small", pk(s_pe, s_hs, s_vs, s_br, s_fs, s_h, s_v),
            model(n, D, HT, HS, HST, HEN, VT, VS, VST, VEN));
      check("mon_full", pk(f_pe, f_hs, f_vs, f_br, f_fs, f_h, f_v),
            model(n, FD, FHT, FHS, FHST, FHEN, FVT, FVS, FVST, FVEN));
    end
  end

  typedef struct {
    int n;
    int h;
    int v;
    bit pe, hs, vs, br, fs;
  } vec_t;

  vec_t tbl[$];

  task automatic wait_n(input int target, input int budget, input string name);
    int g = 0;
    while (n != target && g < budget) begin
      @(negedge clk);
      g++;
    end
    if (n != target) check(name, n, target);
  endtask

  task automatic zero_check(input string name);
    check({name, "_small"}, pk(s_pe, s_hs, s_vs, s_br, s_fs, s_h, s_v), 32'd0);
    check({name, "_full"},  pk(f_pe, f_hs, f_vs, f_br, f_fs, f_h, f_v), 32'd0);
  endtask

  initial begin
    int g, cnt, brc, vlc, fsc;
    //           n    h   v  pe hs vs br fs
    tbl.push_back('{0,   0,  0, 0, 0, 0, 0, 0});
    tbl.push_back('{3,   0,  0, 1, 0, 0, 0, 0});
    tbl.push_back('{4,   1,  0, 0, 0, 0, 0, 0});
    tbl.push_back('{15,  3,  0, 1, 0, 0, 0, 0});
    tbl.push_back('{16,  4,  0, 0, 1, 0, 0, 0});
    tbl.push_back('{24,  6,  0, 0, 1, 0, 0, 0});
    tbl.push_back('{96,  0,  1, 0, 0, 0, 0, 0});
    tbl.push_back('{216, 6,  2, 0, 1, 1, 0, 0});
    tbl.push_back('{308, 5,  3, 0, 1, 1, 0, 0});
    tbl.push_back('{312, 6,  3, 0, 1, 1, 1, 0});
    tbl.push_back('{364, 19, 3, 0, 1, 1, 1, 0});
    tbl.push_back('{368, 20, 3, 0, 1, 1, 0, 0});
    tbl.push_back('{748, 19, 7, 0, 1, 1, 1, 0});
    tbl.push_back('{792, 6,  8, 0, 1, 1, 0, 0});
    tbl.push_back('{959, 23, 9, 1, 1, 1, 0, 0});
    tbl.push_back('{960, 0,  0, 0, 0, 0, 0, 1});
    tbl.push_back('{961, 0,  0, 0, 0, 0, 0, 0});

    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      zero_check("reset_hold");
    end
    @(posedge clk);
    #1 rst = 1'b1;
    mon_en = 1'b1;

    foreach (tbl[i]) begin
      wait_n(tbl[i].n, 5000, $sformatf("tbl%0d_timeout", i));
      check($sformatf("tbl%0d_h", i),  s_h,  tbl[i].h);
      check($sformatf("tbl%0d_v", i),  s_v,  tbl[i].v);
      check($sformatf("tbl%0d_pe", i), s_pe, tbl[i].pe);
      check($sformatf("tbl%0d_hs", i), s_hs, tbl[i].hs);
      check($sformatf("tbl%0d_vs", i), s_vs, tbl[i].vs);
      check($sformatf("tbl%0d_br", i), s_br, tbl[i].br);
      check($sformatf("tbl%0d_fs", i), s_fs, tbl[i].fs);
    end

    // One whole small frame between consecutive frame_start pulses.
    g = 0;
    while (!s_fs && g < 2000) begin
      @(negedge clk);
      g++;
    end
    check("fs_found", s_fs, 1'b1);
    cnt = 0; brc = 0; vlc = 0;
    do begin
      @(negedge clk);
      cnt++;
      brc += s_br;
      vlc += !s_vs;
    end while (!s_fs && cnt < 2000);
    check("fs_spacing", cnt, D * HT * VT);
    check("bright_clks", brc, (HEN - HST + 1) * (VEN - VST + 1) * D);
    check("vsync_low_clks", vlc, VS * HT * D);
    @(negedge clk);
    check("fs_width", s_fs, 1'b0);

    // Full-size first line: hSync edges and low width.
    @(posedge clk);
    #1 rst = 1'b0;
    #1 zero_check("reset_async");
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    g = 0;
    while (!f_hs && g < 5000) begin @(negedge clk); g++; end
    check("hsync_rise_n", n, FHS * FD);
    check("hsync_rise_h", f_h, FHS);
    g = 0;
    while (f_hs && g < 5000) begin @(negedge clk); g++; end
    check("hsync_fall_n", n, FHT * FD);
    check("hsync_fall_h", f_h, 0);
    check("hsync_fall_v", f_v, 1);
    g = 0;
    while (!f_hs && g < 5000) begin @(negedge clk); g++; end
    check("hsync_low_width", n - FHT * FD, FHS * FD);

    // Full-size line wrap at vCount 10 -> 11.
    wait_n(FHT * FD * 11 - 1, 40000, "linewrap_timeout");
    check("linewrap_pre_h", f_h, 799);
    check("linewrap_pre_v", f_v, 10);
    check("linewrap_pre_pe", f_pe, 1'b1);
    @(negedge clk);
    check("linewrap_h", f_h, 0);
    check("linewrap_v", f_v, 11);
    check("linewrap_vs", f_vs, 1'b1);

    // Mid-frame reset on the small raster, then a clean restart without frame_start.
    g = 0;
    while (!(s_h == 10'd12 && s_v == 10'd5) && g < 2000) begin @(negedge clk); g++; end
    check("midreset_found", {s_h, s_v}, {10'd12, 10'd5});
    @(posedge clk);
    #1 rst = 1'b0;
    #1 zero_check("midreset_async");
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    fsc = 0;
    repeat (D * HT * VT) begin
      @(negedge clk);
      fsc += s_fs;
    end
    check("midreset_no_fs", fsc, 0);
    @(negedge clk);
    check("midreset_first_fs", s_fs, 1'b1);

    // Random run lengths interleaved with asynchronous resets at random phases.
    for (int it = 0; it < 6; it++) begin
      repeat ($urandom_range(20, 1200)) @(posedge clk);
      #($urandom_range(1, 8));
      rst = 1'b0;
      #1 zero_check($sformatf("rand_reset%0d", it));
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1 rst = 1'b1;
    end
    repeat (1100) @(posedge clk);

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Video timing generator that drives the pixel-coordinate interface consumed by the display pipeline: `hCount`, `vCount`, `bright`, plus the monitor sync pulses. It divides the system clock down to a pixel rate. It walks an 800×525 raster, 640×480 visible at 60 Hz from a 100 MHz clock, and publishes registered, mutually aligned counters and flags. It sits between the board clock/reset and every pixel-colour block, such as the rectangle/background compositor, that turns (`hCount`, `vCount`, `bright`) into `rgb`.

## Interface
- `CLK_DIV`, 4: system clocks per pixel; must be ≥2.
- `H_TOTAL`, 800: clocks per line, in pixels.
- `H_SYNC`, 96: `hSync` low width, in pixels.
- `H_START`, 144: first visible `hCount`.
- `H_END`, 783: last visible `hCount`.
- `V_TOTAL`, 525: lines per frame.
- `V_SYNC`, 2: `vSync` low width, in lines.
- `V_START`, 35: first visible `vCount`.
- `V_END`, 514: last visible `vCount`.

Ports:
- `clk`, input, 1: system clock, 100 MHz.
- `rst`, input, 1: reset, asynchronous, active-low.
- `pix_en`, output, 1: one-`clk` pixel strobe, high when the divider is at `CLK_DIV-1`.
- `hCount`, output, 10: horizontal position, 0..`H_TOTAL-1`.
- `vCount`, output, 10: vertical position, 0..`V_TOTAL-1`.
- `hSync`, output, 1: horizontal sync, active-low.
- `vSync`, output, 1: vertical sync, active-low.
- `bright`, output, 1: high inside the visible window.
- `frame_start`, output, 1: one-`clk` pulse when the raster returns to (0,0).

## Operation
- **Divider.** `div` is a 2-bit-min counter, 0..`CLK_DIV-1`, that increments every `clk` and wraps.
  - `pix_en` is a pure decode of registered `div`.
- **Horizontal.** On a `clk` edge with `pix_en`=1:
  - `hCount` increments.
  - At `H_TOTAL-1` it wraps to 0 and a line advance occurs.
- **Vertical.** On a line advance:
  - `vCount` increments.
  - At `V_TOTAL-1` it wraps to 0.
  - The horizontal wrap and vertical wrap happen on the same edge.
- **Flags.** All flags are registered and computed from the next-state counters, so they are valid in the same cycle as the counts they describe:
  - `hSync` = 0 when `hCount` < `H_SYNC`.
  - `vSync` = 0 when `vCount` < `V_SYNC`.
  - `bright` = 1 when `H_START` ≤ `hCount` ≤ `H_END` and `V_START` ≤ `vCount` ≤ `V_END`, inclusive.
- **`frame_start`.** High for exactly one `clk`: the cycle after the edge on which (`hCount`,`vCount`) became (0,0) from (`H_TOTAL-1`,`V_TOTAL-1`).
  - Not asserted out of reset.
- **Arithmetic.** All counter compares are unsigned, 10 bits. No counter ever holds a value ≥ its TOTAL.

## Timing
- **Reset values** (`rst`=0, asynchronous): `div`=0, `pix_en`=0, `hCount`=0, `vCount`=0, `hSync`=0, `vSync`=0, `bright`=0, `frame_start`=0.
- **Reset release.**
  - `pix_en` first rises after `CLK_DIV-1` `clk` edges.
  - `hCount` first becomes 1 on edge `CLK_DIV`.
- **Pixel hold.** Each `hCount` value is held for exactly `CLK_DIV` clocks. Outputs change only on the edge where `pix_en`=1, except `pix_en`, `frame_start` and `div`.
- **Raster periods.**
  - Line period: `H_TOTAL`×`CLK_DIV` = 3200 clocks.
  - Frame period: 1,680,000 clocks.
  - `frame_start` spacing is exactly one frame period.
- **Latency.** Zero cycles between `hCount`/`vCount` and their flags: all are updated on the same edge.
- **Mid-frame reset.** Asserting `rst` at any point forces the reset values immediately. Release restarts the frame from (0,0) with no `frame_start` pulse.
- **Wrap bounds.** `hCount` never reads `H_TOTAL`; `vCount` never reads `V_TOTAL`.

## Test plan
- **Reset and divider.** Hold `rst`=0 for 5 clocks, then release.
  - During reset, all outputs read 0.
  - `pix_en` pulses on clocks 3, 7, 11, …
  - `hCount`=1 after clock 4.
- **Horizontal sync edge.**
  - `hSync` rises on the edge where `hCount` 95→96.
  - `hSync` falls on the edge where `hCount` 799→0.
  - `hSync` low width is 384 clocks.
- **Line wrap.**
  - At `hCount`=799, `vCount`=10, the next `pix_en` edge gives `hCount`=0, `vCount`=11 on the same edge.
  - `vSync` stays high.
- **Visible window corners.**
  - `bright`=1 at (144,35), (783,35), (144,514) and (783,514).
  - `bright`=0 at (143,35), (784,35), (144,34) and (144,515).
  - 640×480 = 307,200 bright pixels per frame.
- **Frame wrap.**
  - At (799,524) → (0,0), `frame_start` is high for exactly 1 clock.
  - `vSync` goes 0 for lines 0–1, i.e. 6400 clocks.
  - Two consecutive `frame_start` pulses are 1,680,000 clocks apart.
- **Mid-frame reset.**
  - Assert `rst` at (400,200): outputs are 0 asynchronously, before the next `clk`.
  - After release, counting resumes from (0,0) with no `frame_start`.
